// File: rtl/hz_bus_pkg.sv
// Shared constants for the open-drain tri-state bus transmitter:
// FSM state encoding and default timing parameters.
package hz_bus_pkg;

  localparam int unsigned DefClksPerBit = 16;
  localparam int unsigned DefTurnCycles = 4;

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] StIdle  = 3'd0;
  localparam logic [StateW-1:0] StStart = 3'd1;
  localparam logic [StateW-1:0] StData  = 3'd2;
  localparam logic [StateW-1:0] StStop  = 3'd3;
  localparam logic [StateW-1:0] StTurn  = 3'd4;

endpackage

// File: rtl/hz_bit_timer.sv
// Bit-period timer: counts clocks within one bit while enabled and flags
// the mid-bit sample point and the final cycle of the bit.
module hz_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic mid,
  output logic last
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    mid   = enable && (cnt_q == CntW'(CLKS_PER_BIT / 2));
    last  = enable && (cnt_q == CntW'(CLKS_PER_BIT - 1));
    cnt_d = cnt_q;
    // Held at zero while disabled so every bit period starts aligned.
    if (!enable || last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tristate_tx.sv
// Open-drain byte transmitter: start/8 data LSB-first/stop framing, drives only 0,
// checks released bits for collisions and holds a high-z guard period after each frame.
module tristate_tx import hz_bus_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
  parameter int unsigned TURN_CYCLES  = DefTurnCycles
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  inout  wire        bus_io,
  output logic       bus_oe,
  output logic       busy,
  output logic       done,
  output logic       collision
);

  localparam int unsigned TurnW = $clog2(TURN_CYCLES + 1);

  logic [StateW-1:0] state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [TurnW-1:0]  turn_cnt_q, turn_cnt_d;
  logic              done_q, done_d;
  logic              coll_q, coll_d;

  logic timer_en, bit_mid, bit_last;
  logic drive_zero, line_low;

  assign timer_en = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

  hz_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .enable(timer_en),
    .mid   (bit_mid),
    .last  (bit_last)
  );

  // x/z reads compare as unknown, which never takes the collision branch.
  assign line_low = (bus_io == 1'b0);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    turn_cnt_d = turn_cnt_q;
    done_d     = 1'b0;
    coll_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d   = StStart;
          shift_d   = tx_data;
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (bit_last) state_d = StData;
      end
      StData: begin
        if (bit_mid && shift_q[0] && line_low) begin
          state_d    = StTurn;
          coll_d     = 1'b1;
          turn_cnt_d = '0;
        end else if (bit_last) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (bit_mid && line_low) begin
          state_d    = StTurn;
          coll_d     = 1'b1;
          turn_cnt_d = '0;
        end else if (bit_last) begin
          state_d    = StTurn;
          done_d     = 1'b1;
          turn_cnt_d = '0;
        end
      end
      StTurn: begin
        if (turn_cnt_q == TurnW'(TURN_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          turn_cnt_d = turn_cnt_q + TurnW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      turn_cnt_q <= '0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      done_q     <= done_d;
      coll_q     <= coll_d;
    end
  end

  assign drive_zero = (state_q == StStart) || ((state_q == StData) && !shift_q[0]);

  assign bus_oe    = drive_zero && !reset;
  assign tx_ready  = (state_q == StIdle) && !reset;
  assign busy      = (state_q != StIdle) && !reset;
  assign done      = done_q;
  assign collision = coll_q;

  assign bus_io = bus_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_tristate_tx.sv
// Directed bench for tristate_tx: table of clean frames plus hand-written
// collision, back-to-back, mid-frame reset and idle sequences.
module tb_tristate_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned TC  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       force_low;
  logic       tx_ready, bus_oe, busy, done, collision;
  wire        bus_io;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int coll_seen = 0;

  pullup (bus_io);
  assign bus_io = force_low ? 1'b0 : 1'bz;

  tristate_tx #(
    .CLKS_PER_BIT(CPB),
    .TURN_CYCLES (TC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_io   (bus_io),
    .bus_oe   (bus_oe),
    .busy     (busy),
    .done     (done),
    .collision(collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [9:0] line;  // [0] start bit, [8:1] data LSB first, [9] stop bit
    logic [9:0] mask;  // bits during which the bench pulls the line low
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    done_seen += int'(done);
    coll_seen += int'(collision);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic send(input logic [7:0] data);
    int n;
    wait_ready(n);
    check("send ready", tx_ready, 1'b1);
    tx_data  = data;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Entered one cycle after the accept edge; leaves one cycle after the frame.
  task automatic check_bits(input string name, input logic [9:0] line, input logic [9:0] mask);
    for (int b = 0; b < 10; b++) begin
      logic ok;
      ok = 1'b1;
      for (int c = 0; c < int'(CPB); c++) begin
        force_low = mask[b];
        #1;
        if (bus_io !== line[b]) ok = 1'b0;
        if (!mask[b] && (bus_oe !== !line[b])) ok = 1'b0;
        tick();
      end
      check($sformatf("%s bit%0d", name, b), ok, 1'b1);
    end
    force_low = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;

    vecs[0] = '{"a5",     8'hA5, 10'b1_1010_0101_0, 10'b0};
    vecs[1] = '{"3c",     8'h3C, 10'b1_0011_1100_0, 10'b0};
    vecs[2] = '{"00",     8'h00, 10'b1_0000_0000_0, 10'b0};
    vecs[3] = '{"ff",     8'hFF, 10'b1_1111_1111_0, 10'b0};
    vecs[4] = '{"00 frc", 8'h00, 10'b1_0000_0000_0, 10'b0_1111_1111_0};
    vecs[5] = '{"5a",     8'h5A, 10'b1_0101_1010_0, 10'b0};

    reset     = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    force_low = 1'b0;
    repeat (3) tick();
    check("rst tx_ready", tx_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst bus_oe", bus_oe, 1'b0);
    check("rst done", done, 1'b0);
    check("rst collision", collision, 1'b0);
    check("rst line", bus_io, 1'b1);
    reset = 1'b0;
    #1;
    check("post-rst tx_ready", tx_ready, 1'b1);
    tick();

    for (int i = 0; i < 6; i++) begin
      done_seen = 0;
      coll_seen = 0;
      send(vecs[i].data);
      check_bits(vecs[i].name, vecs[i].line, vecs[i].mask);
      check({vecs[i].name, " done"}, done, 1'b1);
      check({vecs[i].name, " bus_oe turn"}, bus_oe, 1'b0);
      wait_ready(n);
      check({vecs[i].name, " guard"}, n, TC);
      check({vecs[i].name, " done count"}, done_seen, 1);
      check({vecs[i].name, " coll count"}, coll_seen, 0);
    end

    // Collision on data bit 3 of 0xFF (frame cycles 16..19, mid at 18).
    done_seen = 0;
    coll_seen = 0;
    send(8'hFF);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 16) force_low = 1'b1;
    end
    check("ff coll early", collision, 1'b0);
    tick();
    check("ff coll pulse", collision, 1'b1);
    check("ff coll bus_oe", bus_oe, 1'b0);
    check("ff coll busy", busy, 1'b1);
    force_low = 1'b0;
    wait_ready(n);
    check("ff coll guard", n, TC);
    check("ff coll done count", done_seen, 0);
    check("ff coll count", coll_seen, 1);

    // Collision on the stop bit of 0x00 (frame cycles 36..39, mid at 38).
    done_seen = 0;
    coll_seen = 0;
    send(8'h00);
    for (int k = 1; k <= 38; k++) begin
      tick();
      if (k == 36) force_low = 1'b1;
    end
    check("stop coll early", collision, 1'b0);
    tick();
    check("stop coll pulse", collision, 1'b1);
    force_low = 1'b0;
    wait_ready(n);
    check("stop coll guard", n, TC);
    check("stop coll done count", done_seen, 0);

    // Back-to-back frames with tx_valid held high.
    done_seen = 0;
    coll_seen = 0;
    wait_ready(n);
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'h80;
    check_bits("b2b first", 10'b1_0000_0001_0, 10'b0);
    check("b2b first done", done, 1'b1);
    wait_ready(n);
    check("b2b gap", n, TC);
    tick();
    tx_valid = 1'b0;
    check("b2b accepted", tx_ready, 1'b0);
    check_bits("b2b second", 10'b1_1000_0000_0, 10'b0);
    check("b2b second done", done, 1'b1);
    check("b2b done count", done_seen, 2);
    wait_ready(n);

    // Reset asserted during data bit 5 (frame cycles 24..27).
    done_seen = 0;
    coll_seen = 0;
    send(8'hA5);
    for (int k = 1; k <= 25; k++) tick();
    reset = 1'b1;
    tick();
    check("midrst bus_oe", bus_oe, 1'b0);
    check("midrst line", bus_io, 1'b1);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst collision", collision, 1'b0);
    reset = 1'b0;
    tick();
    check("midrst ready", tx_ready, 1'b1);
    check("midrst pulses", done_seen + coll_seen, 0);
    send(8'h3C);
    check_bits("after rst", 10'b1_0011_1100_0, 10'b0);
    check("after rst done", done, 1'b1);
    wait_ready(n);

    begin
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (bus_oe !== 1'b0 || collision !== 1'b0 || busy !== 1'b0 || bus_io !== 1'b1) ok = 1'b0;
      end
      check("idle quiet", ok, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
